// File: rtl/ram_pkg.sv
// Shared types and helpers for the clearable simple-dual-port RAM.
package ram_pkg;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam int unsigned RDW_READ_OLD    = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Widest word the parity helper accepts; callers zero-extend narrower words.
  localparam int unsigned ParityMaxW = 1024;

  function automatic logic calc_parity(input logic [ParityMaxW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every address once, writing zero, after reset or on request.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req_i) begin
          state_d = StClear;
          addr_d  = '0;
        end
      end
      StClear: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StClear;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign busy_o     = (state_q == StClear);
  assign clr_we_o   = busy_o;
  assign clr_addr_o = addr_q;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write and a clear sequencer.
// Define RAM_DP_CLR_PARITY_EN to store a per-word even-parity bit and expose parity_err_o.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned RDW_MODE = RDW_READ_OLD
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clr_req_i,
  output logic                busy_o,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wbe_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
`ifdef RAM_DP_CLR_PARITY_EN
  output logic                parity_err_o,
`endif
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [Depth];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_acc, rd_acc, fwd;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  ram_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_req_i (clr_req_i),
    .busy_o    (busy_o),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  // A clear request drops the same-cycle user access as well.
  assign wr_acc = we_i & ~busy_o & ~clr_req_i;
  assign rd_acc = re_i & ~busy_o & ~clr_req_i;
  assign fwd    = (RDW_MODE == RDW_WRITE_FIRST) && wr_acc && (waddr_i == raddr_i);

  always_comb begin
    wr_merged = mem_q[waddr_i];
    for (int i = 0; i < NumBytes; i++) begin
      if (wbe_i[i]) begin
        wr_merged[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem_q[waddr_i] <= wr_merged;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= fwd ? wr_merged : mem_q[raddr_i];
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

`ifdef RAM_DP_CLR_PARITY_EN
  logic par_q [Depth];
  logic par_err_q;

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      par_q[clr_addr] <= 1'b0;
    end else if (wr_acc) begin
      par_q[waddr_i] <= calc_parity(ParityMaxW'(wr_merged));
    end
  end

  // Forwarded words never touched the array, so they cannot carry a stored-parity error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      par_err_q <= 1'b0;
    end else if (rd_acc) begin
      par_err_q <= fwd ? 1'b0
                       : (par_q[raddr_i] != calc_parity(ParityMaxW'(mem_q[raddr_i])));
    end
  end

  assign parity_err_o = par_err_q;
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: word-level reference model plus directed literal checks.
module tb_ram_dp_clr;

  localparam int unsigned RDW   = 0;
  localparam int unsigned Depth = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        we = 1'b0;
  logic [8:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  wbe = '0;
  logic        re = 1'b0;
  logic [8:0]  raddr = '0;
  logic [15:0] rdata;
  logic        rvalid;
`ifdef RAM_DP_CLR_PARITY_EN
  logic        parity_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ram_dp_clr #(
    .DATA_W  (16),
    .ADDR_W  (9),
    .RDW_MODE(RDW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .clr_req_i   (clr_req),
    .busy_o      (busy),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .wbe_i       (wbe),
    .re_i        (re),
    .raddr_i     (raddr),
`ifdef RAM_DP_CLR_PARITY_EN
    .parity_err_o(parity_err),
`endif
    .rdata_o     (rdata),
    .rvalid_o    (rvalid)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: remaining busy cycles, word array, expected read outputs.
  logic [15:0] m_mem [Depth];
  int          m_left = 0;
  logic        m_rvalid = 1'b0;
  logic [15:0] m_rdata = '0;
  logic        m_init = 1'b0;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  always @(posedge clk) begin
    logic        ok, rd, wr;
    logic [15:0] nw;
    if (reset) begin
      m_init   = 1'b1;
      m_left   = Depth;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      for (int i = 0; i < Depth; i++) m_mem[i] = '0;
    end else if (m_init) begin
      ok = (m_left == 0) && !clr_req;
      rd = re && ok;
      wr = we && ok;
      nw = merge(m_mem[waddr], wdata, wbe);
      if (rd) m_rdata = (RDW == 1 && wr && waddr == raddr) ? nw : m_mem[raddr];
      m_rvalid = rd;
      if (wr) m_mem[waddr] = nw;
      if (m_left > 0) begin
        m_left--;
      end else if (clr_req) begin
        m_left = Depth;
        for (int i = 0; i < Depth; i++) m_mem[i] = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("rvalid", 32'(rvalid), 32'(m_rvalid));
      check("rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  task automatic wr_word(input logic [8:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_word(input logic [8:0] a, input logic [15:0] exp, input string name);
    @(negedge clk);
    re = 1'b1; raddr = a;
    @(negedge clk);
    re = 1'b0;
    check({name, "_rvalid"}, 32'(rvalid), 32'd1);
    check({name, "_rdata"}, 32'(rdata), 32'(exp));
  endtask

  // Called at a negedge; counts consecutive busy samples, optionally poking dropped accesses.
  task automatic count_busy(input int mid_req_at, input bit poke, output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      if (poke && n >= 1 && n <= 10) check("busy_drop_rvalid", 32'(rvalid), 32'd0);
      n++;
      clr_req = (n == mid_req_at);
      we = poke && n <= 9;
      re = poke && n <= 9;
      waddr = 9'd21; raddr = 9'd21; wdata = 16'h5555; wbe = 2'b11;
      @(negedge clk);
    end
    clr_req = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset and initial clear.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    count_busy(0, 1'b0, n);
    check("init_busy_len", 32'(n), 32'd512);
    re = 1'b1; raddr = 9'd0;           // read in the first idle cycle
    @(negedge clk);
    re = 1'b0;
    check("first_idle_rvalid", 32'(rvalid), 32'd1);
    check("first_idle_rdata", 32'(rdata), 32'd0);
    rd_word(9'd255, 16'h0000, "clr255");
    rd_word(9'd511, 16'h0000, "clr511");

    // Byte-enable merge and single-cycle rvalid.
    wr_word(9'd7, 16'hA5C3, 2'b11);
    wr_word(9'd7, 16'h1200, 2'b10);
    rd_word(9'd7, 16'h12C3, "merge7");
    @(negedge clk);
    check("rvalid_pulse", 32'(rvalid), 32'd0);
    wr_word(9'd7, 16'hFFFF, 2'b00);
    rd_word(9'd7, 16'h12C3, "wbe_zero");

    // Read-during-write, same and different address.
    wr_word(9'd3, 16'h0001, 2'b11);
    @(negedge clk);
    we = 1'b1; waddr = 9'd3; wdata = 16'hBEEF; wbe = 2'b11; re = 1'b1; raddr = 9'd3;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("rdw_same", 32'(rdata), (RDW == 1) ? 32'hBEEF : 32'h0001);
    rd_word(9'd3, 16'hBEEF, "after_rdw");
    @(negedge clk);
    we = 1'b1; waddr = 9'd4; wdata = 16'h4444; wbe = 2'b11; re = 1'b1; raddr = 9'd7;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("rdw_diff", 32'(rdata), 32'h12C3);
    rd_word(9'd4, 16'h4444, "diff_wr");

    // Fill, then clear request with a same-cycle write and read.
    for (int i = 0; i < 16; i++) wr_word(9'(i), 16'(i * 257 + 1), 2'b11);
    rd_word(9'd5, 16'h0506, "fill5");
    @(negedge clk);
    clr_req = 1'b1; we = 1'b1; waddr = 9'd20; wdata = 16'hDEAD; wbe = 2'b11;
    re = 1'b1; raddr = 9'd5;
    @(negedge clk);
    clr_req = 1'b0; we = 1'b0; re = 1'b0;
    check("clrreq_rvalid", 32'(rvalid), 32'd0);
    count_busy(0, 1'b1, n);
    check("clrreq_busy_len", 32'(n), 32'd512);
    rd_word(9'd5, 16'h0000, "clr5");
    rd_word(9'd15, 16'h0000, "clr15");
    rd_word(9'd20, 16'h0000, "clr20");
    rd_word(9'd7, 16'h0000, "clr7");

    // Reset in the middle of a clear, and a clear request that must not extend it.
    wr_word(9'd12, 16'h1234, 2'b11);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy(50, 1'b0, n);
    check("reset_mid_busy_len", 32'(n), 32'd512);
    rd_word(9'd12, 16'h0000, "clr12");

`ifdef RAM_DP_CLR_PARITY_EN
    wr_word(9'd9, 16'h0F0F, 2'b11);
    rd_word(9'd9, 16'h0F0F, "par_clean");
    check("par_clean_err", 32'(parity_err), 32'd0);
    @(negedge clk);
    dut.mem_q[9][0] = ~dut.mem_q[9][0];
    m_mem[9][0] = ~m_mem[9][0];
    rd_word(9'd9, 16'h0F0E, "par_flip");
    check("par_flip_err", 32'(parity_err), 32'd1);
    rd_word(9'd4, 16'h0000, "par_other");
    check("par_other_err", 32'(parity_err), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, per-byte write enables and configurable read-during-write behaviour. A built-in clear sequencer zeroes the array one word per cycle, after reset or on request. It is the general-purpose storage block for datapath buffers and register files in the design, replacing fixed-size single-port RAMs.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8.
ADDR_W, 9, address width; DEPTH = 2**ADDR_W words.
RDW_MODE, 0, same-address read-during-write: 0 = read-old (previous contents), 1 = write-first (new merged word).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous active-high reset.
clr_req  in  1  single-cycle pulse; starts a full-array clear.
busy  out  1  high while clearing; all accesses are dropped.
we  in  1  write strobe.
waddr  in  ADDR_W  write address.
wdata  in  DATA_W  write data.
wbe  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
re  in  1  read strobe.
raddr  in  ADDR_W  read address.
rdata  out  DATA_W  registered read data.
rvalid  out  1  rdata valid; 1-cycle pulse per accepted read.

Behaviour:
- Reset (sync, high): rdata=0, rvalid=0, state=CLEAR, clr_addr=0, busy=1. Array contents are not reset directly; the clear sequence zeroes them.
- States: IDLE and CLEAR; busy = (state==CLEAR), registered.
- CLEAR: each cycle writes 0 to clr_addr, then clr_addr++. When clr_addr==DEPTH-1 is written, next state is IDLE. Counting from the first cycle after reset falls, busy stays high exactly DEPTH cycles.
- IDLE with clr_req=1: next state CLEAR, clr_addr=0. Any we/re in that cycle is dropped, so rvalid=0 next cycle.
- clr_req while busy is ignored and does not restart the sequence. Reset asserted mid-clear restarts from address 0.
- Accept rules: a write is accepted when we & !busy & !clr_req. A read is accepted when re & !busy & !clr_req.
- Write: memory[waddr] byte i <= wdata byte i where wbe[i]=1; other bytes hold. wbe=0 is a no-op.
- Read: latency 1. The cycle after an accepted read has rvalid=1 and rdata = word. A cycle with no accepted read has rvalid=0 and rdata holds its last value.
- Same-address read and write in one cycle:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the byte-merged new word.
  - Different addresses are independent.
- Addresses always lie in range: DEPTH=2**ADDR_W, so there is no out-of-range case.
- Reads issued in the cycle busy falls (first IDLE cycle) are accepted.

Optional Feature:
Macro RAM_DP_CLR_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit computed over the stored (merged) word; clear writes parity 0.
  - Extra output parity_err (1 bit) is registered alongside rdata and valid only with rvalid; it is 1 when the stored parity mismatches the recomputed parity.
  - Reset value of parity_err is 0.
  - For RDW_MODE=1 forwarding, parity_err=0.
- When undefined: no parity storage and no parity_err port.

Decomposition:
- Package ram_pkg:
  - state enum {IDLE, CLEAR};
  - RDW_READ_OLD=0 and RDW_WRITE_FIRST=1 constants;
  - parity function.
- Sub-module ram_clr_seq holds the state register, clr_addr counter and busy. It outputs the clear write enable and address, which are muxed onto the array write port ahead of user writes.

Test Plan:
- Reset 2 cycles, release -> busy=1 for exactly 512 cycles. After busy falls, reads at 0, 255 and 511 return 0x0000 with rvalid one cycle later.
- Write 0xA5C3 to addr 7 with wbe=11, then write 0x1200 with wbe=10, then read 7 -> rdata=0x12C3, rvalid pulse of 1 cycle.
- Same-cycle write 0xBEEF and read at addr 3, which previously held 0x0001 -> RDW_MODE=0 gives 0x0001; RDW_MODE=1 gives 0xBEEF.
- Fill addrs 0..15, pulse clr_req together with we to addr 20 -> write dropped; busy for 512 cycles; all reads return 0; we/re during busy give rvalid=0.
- Assert reset at clear cycle 100 -> busy stays high 512 cycles after release; clr_req mid-clear does not extend busy.
- With RAM_DP_CLR_PARITY_EN, force-flip one stored bit at addr 9 via the bench and read -> parity_err=1 with rvalid. An unmodified read gives parity_err=0.
